mac_ctrl_seq: RTL and testbench

MAC_CTRL_SEQ -- requirements
Module: mac_ctrl_seq

---
 rtl/mac_ctrl_seq.sv | 163 ++++++++++++++++
 tb/tb_mac_ctrl_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ctrl_seq.sv
// mac_ctrl_seq -- sequencer for one MAC-array tile.
//
// A tile loads four weight rows, then four input columns, fires the array
// once, waits CALC_LAT cycles for the result, drains sixteen results, and
// pulses DONE.
//
// Ports:
//   CLK          clock, rising edge
//   RSTN         asynchronous active-low reset
//   START        single-cycle tile request, honoured only in IDLE
//   SHAMT_CFG    shift amount, captured when START is accepted
//   MEM_RDY      memory ready; low stalls the load and drain beats
//   WLoad0/WROW0         weight-row strobe and row index
//   ILoad0/ICOL0         input-column strobe and column index
//   START_CALC0          one-cycle array compute trigger
//   shamt0               shift amount latched for the tile
//   OWrite0/ODST0        result write strobe and destination index
//   BUSY                 high whenever the FSM is not in IDLE
//   DONE                 one-cycle completion pulse
//
// Every output is a flop. A beat is issued at the edge that samples
// MEM_RDY=1, so each strobe shows the MEM_RDY value from the previous edge.
// The strobe flop therefore doubles as the MEM_RDY register.

module mac_ctrl_seq #(
    parameter int unsigned CALC_LAT = 7    // 1..15
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic [4:0] SHAMT_CFG,
    input  logic       MEM_RDY,
    output logic       WLoad0,
    output logic [1:0] WROW0,
    output logic       ILoad0,
    output logic [1:0] ICOL0,
    output logic       START_CALC0,
    output logic [4:0] shamt0,
    output logic       OWrite0,
    output logic [3:0] ODST0,
    output logic       BUSY,
    output logic       DONE
);

    // state | meaning
    // IDLE  | waiting for START
    // WLOAD | issuing weight rows 0..3
    // ILOAD | issuing input columns 0..3
    // CALC  | issuing the compute trigger
    // WAIT  | counting CALC_LAT cycles
    // DRAIN | issuing result writes 0..15
    // FIN   | issuing DONE, then back to IDLE
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        ILOAD = 3'd2,
        CALC  = 3'd3,
        WAIT  = 3'd4,
        DRAIN = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(CALC_LAT - 1);

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            cnt         <= '0;
            WLoad0      <= 1'b0;
            WROW0       <= '0;
            ILoad0      <= 1'b0;
            ICOL0       <= '0;
            START_CALC0 <= 1'b0;
            shamt0      <= '0;
            OWrite0     <= 1'b0;
            ODST0       <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            // Strobes are single-cycle by default; indices hold their value.
            WLoad0      <= 1'b0;
            ILoad0      <= 1'b0;
            START_CALC0 <= 1'b0;
            OWrite0     <= 1'b0;
            DONE        <= 1'b0;

            case (state)
                IDLE: begin
                    if (START) begin
                        shamt0 <= SHAMT_CFG;
                        cnt    <= '0;
                        BUSY   <= 1'b1;
                        state  <= WLOAD;
                    end
                end
                WLOAD: begin
                    if (MEM_RDY) begin
                        WLoad0 <= 1'b1;
                        WROW0  <= cnt[1:0];
                        if (cnt == 4'd3) begin
                            cnt   <= '0;
                            state <= ILOAD;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ILOAD: begin
                    if (MEM_RDY) begin
                        ILoad0 <= 1'b1;
                        ICOL0  <= cnt[1:0];
                        if (cnt == 4'd3) begin
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                CALC: begin
                    START_CALC0 <= 1'b1;
                    cnt         <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (MEM_RDY) begin
                        OWrite0 <= 1'b1;
                        ODST0   <= cnt;
                        if (cnt == 4'd15) begin
                            cnt   <= '0;
                            state <= FIN;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_ctrl_seq.sv
// Testbench for mac_ctrl_seq (CALC_LAT = 7).
// The driver pushes each tile's expected beat sequence into a queue. The
// monitor pops the queue and compares whenever a strobe or DONE appears.

module tb_mac_ctrl_seq;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       START = 1'b0;
    logic [4:0] SHAMT_CFG = '0;
    logic       MEM_RDY = 1'b1;
    logic       WLoad0, ILoad0, START_CALC0, OWrite0, BUSY, DONE;
    logic [1:0] WROW0, ICOL0;
    logic [4:0] shamt0;
    logic [3:0] ODST0;

    mac_ctrl_seq #(.CALC_LAT(7)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .SHAMT_CFG(SHAMT_CFG),
        .MEM_RDY(MEM_RDY), .WLoad0(WLoad0), .WROW0(WROW0), .ILoad0(ILoad0),
        .ICOL0(ICOL0), .START_CALC0(START_CALC0), .shamt0(shamt0),
        .OWrite0(OWrite0), .ODST0(ODST0), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // kind: 0 weight, 1 input, 2 calc, 3 drain, 4 done
    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] idx;
        logic [4:0] sh;
    } beat_t;

    beat_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int calc_cyc = 0;
    int n_strobe;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_beat(input logic [2:0] kind, input logic [3:0] idx);
        beat_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got kind=%0d idx=%0d, queue empty", kind, idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx || e.sh != shamt0) begin
                n_fail++;
                $display("FAIL beat_seq: got kind=%0d idx=%0d sh=%0d, want kind=%0d idx=%0d sh=%0d",
                         kind, idx, shamt0, e.kind, e.idx, e.sh);
            end
        end
    endtask

    // Monitor
    always @(negedge CLK) begin
        if (RSTN) begin
            n_strobe = int'(WLoad0) + int'(ILoad0) + int'(START_CALC0) + int'(OWrite0);
            n_chk++;
            if (n_strobe > 1) begin
                n_fail++;
                $display("FAIL onehot: %0d strobes high, want at most 1", n_strobe);
            end
            if (WLoad0)      check_beat(3'd0, {2'b00, WROW0});
            if (ILoad0)      check_beat(3'd1, {2'b00, ICOL0});
            if (START_CALC0) begin
                check_beat(3'd2, 4'd0);
                calc_cyc = cyc;
            end
            if (OWrite0) begin
                check_beat(3'd3, ODST0);
                if (ODST0 == 4'd0) begin
                    n_chk++;
                    if (cyc - calc_cyc != 8) begin
                        n_fail++;
                        $display("FAIL calc_to_drain: gap %0d cycles, want 8", cyc - calc_cyc);
                    end
                end
            end
            if (DONE) begin
                done_cnt++;
                check_beat(3'd4, 4'd0);
            end
        end
    end

    task automatic push_tile(input logic [4:0] sh);
        for (int i = 0; i < 4; i++)  exp_q.push_back({3'd0, 4'(i), sh});
        for (int i = 0; i < 4; i++)  exp_q.push_back({3'd1, 4'(i), sh});
        exp_q.push_back({3'd2, 4'd0, sh});
        for (int i = 0; i < 16; i++) exp_q.push_back({3'd3, 4'(i), sh});
        exp_q.push_back({3'd4, 4'd0, sh});
    endtask

    // Call at a negedge; START is sampled at the following posedge.
    task automatic start_tile(input logic [4:0] sh, output int c0);
        SHAMT_CFG = sh;
        START = 1'b1;
        push_tile(sh);
        c0 = cyc;
        @(negedge CLK);
        START = 1'b0;
        SHAMT_CFG = ~sh;
    endtask

    task automatic wait_done(input int c0, input int exp_len);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (DONE) break;
        end
        n_chk++;
        if (i == 200) begin
            n_fail++;
            $display("FAIL done_timeout: no DONE within 200 cycles, want DONE");
        end else if (cyc - c0 != exp_len) begin
            n_fail++;
            $display("FAIL tile_len: %0d cycles, want %0d", cyc - c0, exp_len);
        end
    endtask

    // kind: 1 input, 2 calc, 3 drain
    task automatic wait_beat(input int kind, input logic [3:0] idx);
        int i;
        logic hit;
        hit = 1'b0;
        for (i = 0; i < 200 && !hit; i++) begin
            @(negedge CLK);
            case (kind)
                1: hit = ILoad0 && (ICOL0 == idx[1:0]);
                2: hit = START_CALC0;
                default: hit = OWrite0 && (ODST0 == idx);
            endcase
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_timeout: kind %0d idx %0d not seen, want seen", kind, idx);
        end
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({WLoad0, WROW0, ILoad0, ICOL0, START_CALC0, shamt0, OWrite0, ODST0, BUSY, DONE} != '0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h, want all 0", name,
                     {WLoad0, WROW0, ILoad0, ICOL0, START_CALC0, shamt0, OWrite0, ODST0, BUSY, DONE});
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int c0;
        int dsnap;

        // Reset state, with START high that must not be taken during reset
        START = 1'b1;
        #1;
        check_zero("reset_state");
        repeat (3) @(negedge CLK);
        START = 1'b0;
        check_zero("reset_held_start");
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);
        check_zero("idle_after_reset");

        // Nominal tile
        start_tile(5'd9, c0);
        wait_done(c0, 34);

        // Stall three cycles in ILOAD after column 1
        @(negedge CLK);
        start_tile(5'd12, c0);
        wait_beat(1, 4'd1);
        MEM_RDY = 1'b0;
        repeat (3) @(negedge CLK);
        MEM_RDY = 1'b1;
        wait_done(c0, 37);

        // START during DRAIN and during FIN are both ignored
        @(negedge CLK);
        start_tile(5'd20, c0);
        wait_beat(3, 4'd4);
        START = 1'b1;
        SHAMT_CFG = 5'd31;
        @(negedge CLK);
        START = 1'b0;
        wait_beat(3, 4'd15);
        START = 1'b1;
        SHAMT_CFG = 5'd31;
        @(negedge CLK);
        START = 1'b0;
        check_val("done_after_fin_start", int'(DONE), 1);
        check_val("tile_len_drain_start", cyc - c0, 34);
        repeat (5) @(negedge CLK);
        check_val("busy_after_ignored", int'(BUSY), 0);
        check_val("shamt_after_ignored", int'(shamt0), 20);

        // Reset during WAIT
        start_tile(5'd7, c0);
        wait_beat(2, 4'd0);
        repeat (2) @(negedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        check_zero("reset_in_wait");
        exp_q.delete();
        dsnap = done_cnt;
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        repeat (30) @(negedge CLK);
        check_zero("idle_after_abort");
        check_val("no_done_after_abort", done_cnt, dsnap);

        // Back-to-back tiles, restart in the DONE cycle
        start_tile(5'd3, c0);
        wait_done(c0, 34);
        start_tile(5'd17, c0);
        wait_done(c0, 34);
        @(negedge CLK);
        check_val("shamt_tile_b", int'(shamt0), 17);
        check_val("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

endmodule
